// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM encoding,
// owner identifiers and the wait-counter width.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } arb_state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-requester round-robin pick: a lone requester always wins, and a tie
// goes to the port that did not own the last grant.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       grant_valid,
    output logic       grant_id
);

    always_comb begin
        grant_valid = |req;
        grant_id    = OWN_CPU;
        if (req == 2'b11) begin
            grant_id = ~last_owner;
        end else if (req[1]) begin
            grant_id = OWN_DBG;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one unified instruction/data memory between the CPU and the debug
// port: round-robin grant, fixed-length wait sequence, one-cycle ready pulse.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ready,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_ready,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("mem_port_arbiter: WAIT_CYCLES must be in 1..15");
    end

    arb_state_t       state_q, state_d;
    logic             owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic             mem_en_q, mem_en_d;
    logic             mem_we_q, mem_we_d;
    logic             busy_q, busy_d;
    logic             grant_valid, grant_id;
    logic             rd_done;

    rr_arb2 u_rr_arb2 (
        .req        ({dbg_req, cpu_req}),
        .last_owner (owner_q),
        .grant_valid(grant_valid),
        .grant_id   (grant_id)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    owner_d = grant_id;
                    we_d    = (grant_id == OWN_DBG) ? dbg_we    : cpu_we;
                    addr_d  = (grant_id == OWN_DBG) ? dbg_addr  : cpu_addr;
                    wdata_d = (grant_id == OWN_DBG) ? dbg_wdata : cpu_wdata;
                    cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Outputs are decoded from the next state so they line up with it.
        mem_en_d = (state_d == ST_ACCESS);
        mem_we_d = mem_en_d && we_d;
        busy_d   = (state_d != ST_IDLE);
    end

    assign rd_done = (state_q == ST_ACCESS) && (cnt_q == '0) && !we_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWN_DBG;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            mem_en_q <= mem_en_d;
            mem_we_q <= mem_we_d;
            busy_q   <= busy_d;
        end
    end

    // Per-port read-data and ready registers; index 0 is the CPU, 1 is debug.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic [DW-1:0] rdata_q, rdata_d;
        logic          ready_q, ready_d;

        always_comb begin
            rdata_d = rdata_q;
            if (rd_done && (owner_q == 1'(gi))) begin
                rdata_d = mem_rdata;
            end
            ready_d = (state_d == ST_DONE) && (owner_d == 1'(gi));
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                rdata_q <= '0;
                ready_q <= 1'b0;
            end else begin
                rdata_q <= rdata_d;
                ready_q <= ready_d;
            end
        end
    end

    assign cpu_rdata = g_port[0].rdata_q;
    assign cpu_ready = g_port[0].ready_q;
    assign dbg_rdata = g_port[1].rdata_q;
    assign dbg_ready = g_port[1].ready_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance A with WAIT_CYCLES=2, instance B with
// WAIT_CYCLES=1, each backed by a small word-addressed memory model.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        port;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    exp_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Instance A signals
    logic        cpu_req_a, cpu_we_a, dbg_req_a, dbg_we_a;
    logic [31:0] cpu_addr_a, cpu_wdata_a, dbg_addr_a, dbg_wdata_a;
    logic [31:0] cpu_rdata_a, dbg_rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
    logic        cpu_ready_a, dbg_ready_a, mem_en_a, mem_we_a, busy_a, owner_a;
    // Instance B signals
    logic        cpu_req_b, cpu_we_b, dbg_req_b, dbg_we_b;
    logic [31:0] cpu_addr_b, cpu_wdata_b, dbg_addr_b, dbg_wdata_b;
    logic [31:0] cpu_rdata_b, dbg_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
    logic        cpu_ready_b, dbg_ready_b, mem_en_b, mem_we_b, busy_b, owner_b;

    mem_port_arbiter #(.AW(32), .DW(32), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req_a), .cpu_we(cpu_we_a), .cpu_addr(cpu_addr_a),
        .cpu_wdata(cpu_wdata_a), .cpu_rdata(cpu_rdata_a), .cpu_ready(cpu_ready_a),
        .dbg_req(dbg_req_a), .dbg_we(dbg_we_a), .dbg_addr(dbg_addr_a),
        .dbg_wdata(dbg_wdata_a), .dbg_rdata(dbg_rdata_a), .dbg_ready(dbg_ready_a),
        .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a),
        .busy(busy_a), .owner(owner_a)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .WAIT_CYCLES(1)) dut_b (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req_b), .cpu_we(cpu_we_b), .cpu_addr(cpu_addr_b),
        .cpu_wdata(cpu_wdata_b), .cpu_rdata(cpu_rdata_b), .cpu_ready(cpu_ready_b),
        .dbg_req(dbg_req_b), .dbg_we(dbg_we_b), .dbg_addr(dbg_addr_b),
        .dbg_wdata(dbg_wdata_b), .dbg_rdata(dbg_rdata_b), .dbg_ready(dbg_ready_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b),
        .busy(busy_b), .owner(owner_b)
    );

    // Memory models with a backdoor preload path
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic        bd_we_a = 1'b0, bd_we_b = 1'b0;
    logic [31:0] bd_addr = '0, bd_data = '0;

    always @(posedge clk) begin
        if (bd_we_a) mem_a[bd_addr[9:2]] <= bd_data;
        else if (mem_en_a && mem_we_a) mem_a[mem_addr_a[9:2]] <= mem_wdata_a;
    end
    always @(posedge clk) begin
        if (bd_we_b) mem_b[bd_addr[9:2]] <= bd_data;
        else if (mem_en_b && mem_we_b) mem_b[mem_addr_b[9:2]] <= mem_wdata_b;
    end
    assign mem_rdata_a = mem_a[mem_addr_a[9:2]];
    assign mem_rdata_b = mem_b[mem_addr_b[9:2]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input bit sel_b, input logic [31:0] a, input logic [31:0] d);
        bd_addr = a;
        bd_data = d;
        if (sel_b) bd_we_b = 1'b1;
        else       bd_we_a = 1'b1;
        tick();
        bd_we_a = 1'b0;
        bd_we_b = 1'b0;
    endtask

    task automatic clear_inputs();
        cpu_req_a = 0; cpu_we_a = 0; cpu_addr_a = '0; cpu_wdata_a = '0;
        dbg_req_a = 0; dbg_we_a = 0; dbg_addr_a = '0; dbg_wdata_a = '0;
        cpu_req_b = 0; cpu_we_b = 0; cpu_addr_b = '0; cpu_wdata_b = '0;
        dbg_req_b = 0; dbg_we_b = 0; dbg_addr_b = '0; dbg_wdata_b = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        exp_q.delete();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        tests++;
        if ({mem_en_a, mem_we_a, busy_a, cpu_ready_a, dbg_ready_a} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl_a: got %b expected 00000",
                     {mem_en_a, mem_we_a, busy_a, cpu_ready_a, dbg_ready_a});
        end
        tests++;
        if ({mem_addr_a, mem_wdata_a, cpu_rdata_a, dbg_rdata_a} !== 128'd0) begin
            fails++;
            $display("FAIL reset_data_a: addr %h wdata %h crd %h drd %h expected all 0",
                     mem_addr_a, mem_wdata_a, cpu_rdata_a, dbg_rdata_a);
        end
        tests++;
        if (owner_a !== 1'b1 || owner_b !== 1'b1) begin
            fails++;
            $display("FAIL reset_owner: got a=%b b=%b expected 1", owner_a, owner_b);
        end
        tests++;
        if ({mem_en_b, busy_b, cpu_ready_b, dbg_ready_b} !== 4'b0) begin
            fails++;
            $display("FAIL reset_ctrl_b: got %b expected 0000",
                     {mem_en_b, busy_b, cpu_ready_b, dbg_ready_b});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_cpu_read();
        int   c0;
        exp_t e;
        preload(1'b0, 32'h40, 32'hDEADBEEF);
        cpu_req_a = 1; cpu_we_a = 0; cpu_addr_a = 32'h40;
        exp_q.push_back('{port: 1'b0, data: 32'hDEADBEEF});
        c0 = cyc;
        for (int k = 1; k <= 5; k++) begin
            tick();
            tests++;
            if (mem_en_a !== (k == 1 || k == 2) || cpu_ready_a !== (k == 3)) begin
                fails++;
                $display("FAIL cpu_read_timing cycle %0d: mem_en %b ready %b expected %b %b",
                         cyc - c0, mem_en_a, cpu_ready_a, (k == 1 || k == 2), (k == 3));
            end
            if (k <= 2) begin
                tests++;
                if (mem_addr_a !== 32'h40) begin
                    fails++;
                    $display("FAIL cpu_read_addr: got %h expected 00000040", mem_addr_a);
                end
            end
            if (cpu_ready_a) begin
                cpu_req_a = 0;
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL cpu_read_extra_ready: got ready expected none");
                end else begin
                    e = exp_q.pop_front();
                    tests++;
                    if (cpu_rdata_a !== e.data) begin
                        fails++;
                        $display("FAIL cpu_read_data: got %h expected %h", cpu_rdata_a, e.data);
                    end
                end
            end
        end
        tests++;
        if (exp_q.size() != 0 || dbg_rdata_a !== 32'h0) begin
            fails++;
            $display("FAIL cpu_read_done: pending %0d dbg_rdata %h expected 0 and 00000000",
                     exp_q.size(), dbg_rdata_a);
        end
        exp_q.delete();
    endtask

    task automatic test_alternate();
        int   c0;
        int   n;
        exp_t e;
        do_reset();
        preload(1'b0, 32'h10, 32'hAAAA0001);
        preload(1'b0, 32'h20, 32'hBBBB0002);
        for (int i = 0; i < 4; i++)
            exp_q.push_back('{port: 1'(i % 2), data: (i % 2 == 0) ? 32'hAAAA0001 : 32'hBBBB0002});
        cpu_req_a = 1; cpu_addr_a = 32'h10;
        dbg_req_a = 1; dbg_addr_a = 32'h20;
        c0 = cyc;
        n = 0;
        for (int k = 1; k <= 20 && n < 4; k++) begin
            tick();
            if ((cpu_ready_a && dbg_ready_a) || (mem_en_a && (cpu_ready_a || dbg_ready_a))) begin
                tests++; fails++;
                $display("FAIL alt_overlap cycle %0d: cpu_ready %b dbg_ready %b mem_en %b",
                         k, cpu_ready_a, dbg_ready_a, mem_en_a);
            end
            if (cpu_ready_a || dbg_ready_a) begin
                e = exp_q.pop_front();
                tests++;
                if (dbg_ready_a !== e.port || k != 3 + 4 * n) begin
                    fails++;
                    $display("FAIL alt_grant %0d: port %b at cycle %0d expected port %b at cycle %0d",
                             n, dbg_ready_a, k, e.port, 3 + 4 * n);
                end
                tests++;
                if ((e.port ? dbg_rdata_a : cpu_rdata_a) !== e.data) begin
                    fails++;
                    $display("FAIL alt_data %0d: got %h expected %h", n,
                             e.port ? dbg_rdata_a : cpu_rdata_a, e.data);
                end
                n++;
                if (n == 4) begin
                    cpu_req_a = 0;
                    dbg_req_a = 0;
                end
            end
        end
        tests++;
        if (n != 4) begin
            fails++;
            $display("FAIL alt_timeout: got %0d grants expected 4", n);
        end
        cpu_req_a = 0; dbg_req_a = 0;
        exp_q.delete();
        tick();
    endtask

    task automatic test_dbg_write_cpu_read();
        exp_t e;
        int   seen;
        do_reset();
        dbg_req_a = 1; dbg_we_a = 1; dbg_addr_a = 32'h100; dbg_wdata_a = 32'h12345678;
        exp_q.push_back('{port: 1'b1, data: 32'h0});
        seen = 0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            tests++;
            if (mem_we_a !== (k == 1 || k == 2)) begin
                fails++;
                $display("FAIL wr_mem_we cycle %0d: got %b expected %b", k, mem_we_a, (k == 1 || k == 2));
            end
            if (dbg_ready_a) begin
                dbg_req_a = 0; dbg_we_a = 0;
                seen++;
                e = exp_q.pop_front();
                tests++;
                if (k != 3 || dbg_rdata_a !== e.data) begin
                    fails++;
                    $display("FAIL wr_ready: cycle %0d dbg_rdata %h expected cycle 3 data %h",
                             k, dbg_rdata_a, e.data);
                end
            end
        end
        cpu_req_a = 1; cpu_we_a = 0; cpu_addr_a = 32'h100;
        exp_q.push_back('{port: 1'b0, data: 32'h12345678});
        for (int k = 1; k <= 6 && seen < 2; k++) begin
            tick();
            if (mem_we_a) begin
                tests++; fails++;
                $display("FAIL rd_mem_we: got 1 expected 0 during read");
            end
            if (cpu_ready_a) begin
                cpu_req_a = 0;
                seen++;
                e = exp_q.pop_front();
                tests++;
                if (cpu_rdata_a !== e.data) begin
                    fails++;
                    $display("FAIL rd_after_wr: got %h expected %h", cpu_rdata_a, e.data);
                end
            end
        end
        tests++;
        if (seen != 2 || dbg_rdata_a !== 32'h0) begin
            fails++;
            $display("FAIL wr_rd_done: readies %0d dbg_rdata %h expected 2 and 00000000",
                     seen, dbg_rdata_a);
        end
        cpu_req_a = 0; dbg_req_a = 0;
        exp_q.delete();
    endtask

    task automatic test_reset_mid_access();
        exp_t e;
        bit   got;
        do_reset();
        cpu_req_a = 1; cpu_we_a = 0; cpu_addr_a = 32'h40;
        tick();
        tick();
        reset = 1'b1;
        cpu_req_a = 0;
        tick();
        tests++;
        if ({mem_en_a, mem_we_a, busy_a, cpu_ready_a, dbg_ready_a} !== 5'b0 ||
            mem_addr_a !== 32'h0 || cpu_rdata_a !== 32'h0 || owner_a !== 1'b1) begin
            fails++;
            $display("FAIL midreset_outputs: ctrl %b addr %h crd %h owner %b expected 0 0 0 1",
                     {mem_en_a, mem_we_a, busy_a, cpu_ready_a, dbg_ready_a},
                     mem_addr_a, cpu_rdata_a, owner_a);
        end
        reset = 1'b0;
        cpu_req_a = 1; cpu_addr_a = 32'h10;
        dbg_req_a = 1; dbg_addr_a = 32'h20;
        exp_q.push_back('{port: 1'b0, data: 32'hAAAA0001});
        got = 0;
        for (int k = 1; k <= 6 && !got; k++) begin
            tick();
            if (cpu_ready_a || dbg_ready_a) begin
                got = 1;
                e = exp_q.pop_front();
                tests++;
                if (dbg_ready_a !== e.port || cpu_rdata_a !== e.data) begin
                    fails++;
                    $display("FAIL midreset_first_tie: port %b data %h expected port %b data %h",
                             dbg_ready_a, cpu_rdata_a, e.port, e.data);
                end
                cpu_req_a = 0; dbg_req_a = 0;
            end
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL midreset_timeout: got no ready expected cpu_ready");
        end
        cpu_req_a = 0; dbg_req_a = 0;
        exp_q.delete();
        tick();
    endtask

    task automatic test_req_drop();
        exp_t e;
        bit   got;
        preload(1'b0, 32'h80, 32'hCAFEF00D);
        preload(1'b0, 32'h84, 32'h0BADBEEF);
        cpu_req_a = 1; cpu_we_a = 0; cpu_addr_a = 32'h80;
        exp_q.push_back('{port: 1'b0, data: 32'hCAFEF00D});
        got = 0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) begin
                cpu_req_a = 0;
                cpu_addr_a = 32'h84;
            end
            if (k <= 2) begin
                tests++;
                if (mem_en_a !== 1'b1 || mem_addr_a !== 32'h80) begin
                    fails++;
                    $display("FAIL drop_addr cycle %0d: en %b addr %h expected 1 00000080",
                             k, mem_en_a, mem_addr_a);
                end
            end
            if (cpu_ready_a) begin
                got = 1;
                e = exp_q.pop_front();
                tests++;
                if (k != 3 || cpu_rdata_a !== e.data) begin
                    fails++;
                    $display("FAIL drop_ready: cycle %0d data %h expected cycle 3 data %h",
                             k, cpu_rdata_a, e.data);
                end
            end
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL drop_timeout: got no cpu_ready expected one");
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   n;
        int   en_cnt;
        preload(1'b1, 32'h0, 32'h11111111);
        preload(1'b1, 32'h4, 32'h22222222);
        preload(1'b1, 32'h8, 32'h33333333);
        do_reset();
        for (int i = 0; i < 3; i++)
            exp_q.push_back('{port: 1'b1, data: 32'h11111111 * (i + 1)});
        dbg_req_b = 1; dbg_we_b = 0; dbg_addr_b = 32'h0;
        n = 0;
        en_cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (mem_en_b) en_cnt++;
            tests++;
            if (mem_en_b !== (k < 8 && k % 3 == 1) || cpu_ready_b !== 1'b0) begin
                fails++;
                $display("FAIL b2b_en cycle %0d: mem_en %b cpu_ready %b expected %b 0",
                         k, mem_en_b, cpu_ready_b, (k < 8 && k % 3 == 1));
            end
            if (dbg_ready_b) begin
                e = exp_q.pop_front();
                tests++;
                if (k != 2 + 3 * n || dbg_rdata_b !== e.data) begin
                    fails++;
                    $display("FAIL b2b_read %0d: cycle %0d data %h expected cycle %0d data %h",
                             n, k, dbg_rdata_b, 2 + 3 * n, e.data);
                end
                n++;
                if (n < 3) dbg_addr_b = 32'(4 * n);
                else       dbg_req_b = 0;
            end
        end
        tests++;
        if (n != 3 || en_cnt != 3) begin
            fails++;
            $display("FAIL b2b_count: readies %0d en cycles %0d expected 3 3", n, en_cnt);
        end
        dbg_req_b = 0;
        exp_q.delete();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_cpu_read();
        test_alternate();
        test_dbg_write_cpu_read();
        test_reset_mid_access();
        test_req_drop();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
